// File: rtl/riscv_test_monitor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// riscv_test_monitor : pass/fail/timeout monitor for riscv-tests runs.
// Optional writeback history buffer: define TEST_MONITOR_HIST_EN.
// Revision: 1.0
// ----------------------------------------------------------------------------
module riscv_test_monitor #(
  parameter int                ADDR_W         = 32,
  parameter int                DATA_W         = 32,
  parameter logic [ADDR_W-1:0] TOHOST_ADDR    = 32'h0000_1000,
  parameter int                TIMEOUT_CYCLES = 100000,
  parameter int                CNT_W          = 32,
  parameter int                HIST_DEPTH     = 8
) (
  input  logic                          sys_clk_i,
  input  logic                          sys_rst_i,
  input  logic                          run_en_i,
  input  logic                          st_valid_i,
  input  logic [ADDR_W-1:0]             st_addr_i,
  input  logic [DATA_W-1:0]             st_data_i,
  input  logic [3:0]                    st_be_i,
  input  logic                          wb_valid_i,
  input  logic [4:0]                    wb_rd_i,
  input  logic [DATA_W-1:0]             wb_data_i,
`ifdef TEST_MONITOR_HIST_EN
  input  logic [$clog2(HIST_DEPTH)-1:0] hist_idx_i,
  output logic [4:0]                    hist_rd_o,
  output logic [DATA_W-1:0]             hist_data_o,
  output logic [$clog2(HIST_DEPTH):0]   hist_cnt_o,
`endif
  output logic                          done_o,
  output logic                          pass_o,
  output logic                          fail_o,
  output logic                          timeout_o,
  output logic [DATA_W-2:0]             fail_code_o,
  output logic [CNT_W-1:0]              cycle_count_o,
  output logic [CNT_W-1:0]              retire_count_o,
  output logic [DATA_W-1:0]             gp_shadow_o
);

  if (DATA_W != 32 || TIMEOUT_CYCLES < 2 || HIST_DEPTH < 2 ||
      (HIST_DEPTH & (HIST_DEPTH - 1)) != 0 || TOHOST_ADDR[1:0] != 2'b00) begin : g_bad_params
    $error("riscv_test_monitor: illegal parameter set");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4
  } state_e;

  state_e              state_q;
  logic [CNT_W-1:0]    cycle_q, cycle_d;
  logic [CNT_W-1:0]    retire_q, retire_d;
  logic                done_q, pass_q, fail_q, timeout_q;
  logic [DATA_W-2:0]   fail_code_q;
  logic [DATA_W-1:0]   gp_q;

  logic tohost_hit;
  logic tohost_pass;
  logic timeout_hit;

  // Only full-word odd values at tohost are verdicts; even values are syscalls.
  assign tohost_hit  = st_valid_i && (st_addr_i == TOHOST_ADDR) &&
                       (st_be_i == 4'hF) && st_data_i[0];
  assign tohost_pass = (st_data_i == DATA_W'(1));
  assign timeout_hit = (64'(cycle_q) == 64'(TIMEOUT_CYCLES - 1));

  assign cycle_d  = (&cycle_q) ? cycle_q : cycle_q + CNT_W'(1);
  assign retire_d = (wb_valid_i && !(&retire_q)) ? retire_q + CNT_W'(1) : retire_q;

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      state_q     <= S_IDLE;
      cycle_q     <= '0;
      retire_q    <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_code_q <= '0;
      gp_q        <= '0;
    end else begin
      if (wb_valid_i && (wb_rd_i == 5'd3)) begin
        gp_q <= wb_data_i;
      end
      case (state_q)
        S_IDLE: begin
          if (run_en_i) begin
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          cycle_q  <= cycle_d;
          retire_q <= retire_d;
          // A store verdict in the expiry cycle takes priority over the timeout.
          if (tohost_hit) begin
            done_q <= 1'b1;
            if (tohost_pass) begin
              state_q <= S_PASS;
              pass_q  <= 1'b1;
            end else begin
              state_q     <= S_FAIL;
              fail_q      <= 1'b1;
              fail_code_q <= st_data_i[DATA_W-1:1];
            end
          end else if (timeout_hit) begin
            state_q   <= S_TIMEOUT;
            timeout_q <= 1'b1;
            done_q    <= 1'b1;
          end else if (!run_en_i) begin
            state_q <= S_IDLE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign done_o         = done_q;
  assign pass_o         = pass_q;
  assign fail_o         = fail_q;
  assign timeout_o      = timeout_q;
  assign fail_code_o    = fail_code_q;
  assign cycle_count_o  = cycle_q;
  assign retire_count_o = retire_q;
  assign gp_shadow_o    = gp_q;

`ifdef TEST_MONITOR_HIST_EN
  localparam int HIST_AW = $clog2(HIST_DEPTH);

  logic [4:0]        hist_rd_q   [HIST_DEPTH];
  logic [DATA_W-1:0] hist_data_q [HIST_DEPTH];
  logic [HIST_AW-1:0] hist_wptr_q;
  logic [HIST_AW:0]   hist_cnt_q;
  logic [HIST_AW-1:0] hist_sel;
  logic               hist_we;

  // x0 writes retire but are never recorded.
  assign hist_we  = (state_q == S_RUN) && wb_valid_i && (wb_rd_i != 5'd0);
  assign hist_sel = hist_wptr_q - HIST_AW'(1) - hist_idx_i;

  always_ff @(posedge sys_clk_i or posedge sys_rst_i) begin
    if (sys_rst_i) begin
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_rd_q[i]   <= '0;
        hist_data_q[i] <= '0;
      end
      hist_wptr_q <= '0;
      hist_cnt_q  <= '0;
    end else if (hist_we) begin
      hist_rd_q[hist_wptr_q]   <= wb_rd_i;
      hist_data_q[hist_wptr_q] <= wb_data_i;
      hist_wptr_q              <= hist_wptr_q + HIST_AW'(1);
      if (hist_cnt_q != (HIST_AW+1)'(HIST_DEPTH)) begin
        hist_cnt_q <= hist_cnt_q + (HIST_AW+1)'(1);
      end
    end
  end

  assign hist_rd_o   = hist_rd_q[hist_sel];
  assign hist_data_o = hist_data_q[hist_sel];
  assign hist_cnt_o  = hist_cnt_q;
`endif

endmodule
`default_nettype wire

// File: doc/riscv_test_monitor.md
Name: riscv_test_monitor

Overview:
Synthesisable pass/fail monitor for riscv-tests (rv32ui-p-*) runs on the pipelined core; it supersedes hand-inspected register probes in the CPU bench.
- Snoops the data-memory store bus for the tohost word and the register-file writeback port.
- Reports pass, fail (with the failing test number), or timeout.
- Keeps cycle and retire counters and a gp shadow register.
- Instantiated beside the core in both the simulation top and the FPGA top, where done/pass drive LEDs.

Parameters:
ADDR_W, 32, width of the data-memory byte address.
DATA_W, 32, width of store data and writeback data; must be 32 in this generation.
TOHOST_ADDR, 32'h0000_1000, byte address of the tohost word; must be 4-byte aligned.
TIMEOUT_CYCLES, 100000, number of RUN cycles before timeout is declared; must be >= 2.
CNT_W, 32, width of cycle_count and retire_count.
HIST_DEPTH, 8, depth of the writeback history buffer; power of 2; used only with the optional feature.

Ports:
sys_clk  in  1  core clock.
sys_rst  in  1  asynchronous, active-high reset.
run_en  in  1  level; the monitor leaves IDLE and starts counting when this is high.
st_valid  in  1  a data-memory store is issued this cycle.
st_addr  in  ADDR_W  store byte address.
st_data  in  DATA_W  store data.
st_be  in  4  store byte enables.
wb_valid  in  1  register writeback, i.e. instruction retire, this cycle.
wb_rd  in  5  writeback destination register.
wb_data  in  DATA_W  writeback data.
done  out  1  sticky; the test has ended.
pass  out  1  sticky; tohost received 1.
fail  out  1  sticky; tohost received an odd value other than 1.
timeout  out  1  sticky; TIMEOUT_CYCLES elapsed with no verdict.
fail_code  out  DATA_W-1  st_data>>1 of the failing store (the riscv-tests test number).
cycle_count  out  CNT_W  number of cycles spent in RUN.
retire_count  out  CNT_W  number of wb_valid pulses seen in RUN.
gp_shadow  out  DATA_W  last value written to x3.

Behaviour:
- Reset: sys_rst asynchronously forces the FSM to IDLE and clears every output and counter to 0. This also applies mid-run; no verdict survives a reset.
- FSM states: IDLE, RUN, PASS, FAIL, TIMEOUT.
  - IDLE -> RUN on a rising edge with run_en=1.
  - PASS, FAIL and TIMEOUT are terminal; only reset leaves them.
  - run_en dropping to 0 while in RUN returns the FSM to IDLE. Counters are held, not cleared.
- Qualifying store (evaluated only in RUN): st_valid=1, st_addr==TOHOST_ADDR, st_be==4'b1111, st_data[0]==1.
  - Partial-width stores and even data values at TOHOST_ADDR are ignored (syscall or unused convention).
- Verdict:
  - A qualifying store with st_data==1 -> PASS.
  - Any other qualifying store -> FAIL, with fail_code <= st_data[DATA_W-1:1].
- Latency: done, pass, fail and fail_code are registered, visible the cycle after the qualifying store edge. done = pass|fail|timeout.
- Timeout: in RUN, cycle_count increments every cycle.
  - When cycle_count == TIMEOUT_CYCLES-1 and no qualifying store occurs in the same cycle -> TIMEOUT.
  - If a qualifying store and the timeout condition coincide, the store verdict wins.
- retire_count increments on wb_valid in RUN only.
- Both counters saturate at all-ones and never wrap. Both freeze in the terminal states and in IDLE.
- gp_shadow updates on wb_valid && wb_rd==3 in any state except after reset-hold. It keeps tracking in terminal states for post-mortem.
- Writes with wb_rd==0 never update anything except retire_count.
- Stores in IDLE or in terminal states are ignored.

Optional Feature:
Macro TEST_MONITOR_HIST_EN.
- Defined: adds an HIST_DEPTH-entry circular buffer of {wb_rd, wb_data} captured on every wb_valid in RUN.
  - Write pointer wraps modulo HIST_DEPTH; the oldest entry is overwritten.
  - Capture freezes on entry to any terminal state.
  - Extra ports:
    - hist_idx in log2(HIST_DEPTH): 0 selects the newest entry.
    - hist_rd out 5 and hist_data out DATA_W: combinational readout of the selected entry.
    - hist_cnt out log2(HIST_DEPTH)+1: number of valid entries, saturating at HIST_DEPTH.
  - Reset clears all entries and hist_cnt.
- Undefined: no buffer and no extra ports; all other behaviour is identical.

Test Plan:
1. Reset, run_en=1, 50 cycles with 20 wb_valid pulses, then a store of 32'h1 to TOHOST_ADDR with be=4'hF -> next cycle pass=1, done=1, fail=0, cycle_count=51, retire_count=20; counters then frozen.
2. Store 32'h0000_000B (test 5) to TOHOST_ADDR -> fail=1, fail_code=5, pass=0; a later store of 32'h1 leaves the verdict unchanged.
3. TIMEOUT_CYCLES=16, no stores -> timeout=1 exactly 16 cycles after RUN entry. Variant with a qualifying store of 32'h1 in the cycle where cycle_count==15 -> pass=1, timeout=0.
4. Stores to TOHOST_ADDR with be=4'h1, with data 32'h2, and to TOHOST_ADDR+4 with data 32'h1 -> no verdict, done=0.
5. wb_valid with rd=3/data=32'h7, then rd=0/data=32'hFF -> gp_shadow=7. Assert sys_rst mid-run -> all outputs 0 immediately, without waiting for a clock edge.
6. With TEST_MONITOR_HIST_EN, HIST_DEPTH=8, 10 writebacks of rd=i/data=i for i=1..10 -> hist_cnt=8; hist_idx=0 reads rd=10; hist_idx=7 reads rd=3.
